e203_clkgate_mgr: RTL and testbench

Parametrised, multi-channel successor to the core clock controller. It gates `N_CH` clock domains (IFU/EXU/LSU/BIU/ITCM/DTCM by default) from per-channel activity requests. Each channel has:
- a programmable hold-off (hysteresis) window,
- an optional SRAM light-sleep entry delay,
- a one-cycle wake state, and a ready flag that tells the requester when the domain is usable.

It sits between the core's activity signals and the `e203_clkgate` cells, next to the always-on clock.

---
 rtl/e203_clkgate_mgr_pkg.sv | 22 ++
 rtl/e203_clkgate.sv | 18 +
 rtl/e203_clkgate_chan.sv | 101 ++++++++++
 rtl/e203_clkgate_mgr.sv | 57 +++++
 tb/tb_e203_clkgate_mgr.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/e203_clkgate_mgr_pkg.sv
// Shared definitions for the multi-channel clock gate manager:
// per-channel state encoding and the counter width helper.
package e203_clkgate_mgr_pkg;

   typedef enum logic [2:0] {
      ST_RUN  = 3'd0,
      ST_HOLD = 3'd1,
      ST_OFF  = 3'd2,
      ST_LS   = 3'd3,
      ST_WAKE = 3'd4
   } chan_st_e;

   // Counter must hold the larger of the two reload values; never narrower than 1 bit.
   function automatic int cw_of(input int hold_cyc, input int ls_dly);
      int mx;
      int w;
      mx = (hold_cyc > ls_dly) ? hold_cyc : ls_dly;
      w  = $clog2(mx + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/e203_clkgate.sv
// Glitch-free clock gate: enable is captured while the clock is low and
// held through the high phase; test_mode forces the clock through.
module e203_clkgate (
   input  logic clk_in,
   input  logic test_mode,
   input  logic clock_en,
   output logic clk_out
);

   logic enb;

   always_latch begin
      if (!clk_in) enb = clock_en | test_mode;
   end

   assign clk_out = enb & clk_in;

endmodule

// File: rtl/e203_clkgate_chan.sv
// One gated clock domain: RUN/HOLD/OFF/LS/WAKE sequencing, hold-off and
// light-sleep counter, registered light-sleep output and ready flag.
module e203_clkgate_chan
   import e203_clkgate_mgr_pkg::*;
#(
   parameter int HOLD_CYC = 1,
   parameter int LS_DLY   = 4,
   parameter bit LS_EN    = 1'b0,
   parameter int CW       = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic test_mode,
   input  logic req,
   output logic clk_out,
   output logic ls,
   output logic rdy,
   output logic idle
);

   localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
   localparam logic [CW-1:0] OFF_LD    = CW'((LS_DLY > 0) ? LS_DLY - 1 : 0);
   localparam bit            OFF_TO_LS = LS_EN && (LS_DLY == 0);

   chan_st_e        st;
   logic [CW-1:0]   cnt;
   logic            ls_q;
   logic            en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st   <= ST_RUN;
         cnt  <= '0;
         ls_q <= 1'b0;
      end else begin
         case (st)
            ST_RUN: begin
               if (!req) begin
                  if (HOLD_CYC > 0) begin
                     st  <= ST_HOLD;
                     cnt <= HOLD_LD;
                  end else begin
                     st   <= OFF_TO_LS ? ST_LS : ST_OFF;
                     cnt  <= OFF_LD;
                     ls_q <= OFF_TO_LS;
                  end
               end
            end
            ST_HOLD: begin
               if (req) begin
                  st <= ST_RUN;
               end else if (cnt == '0) begin
                  st   <= OFF_TO_LS ? ST_LS : ST_OFF;
                  cnt  <= OFF_LD;
                  ls_q <= OFF_TO_LS;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            // Non-memory channels park here with the counter frozen.
            ST_OFF: begin
               if (req) begin
                  st <= ST_RUN;
               end else if (LS_EN) begin
                  if (cnt == '0) begin
                     st   <= ST_LS;
                     ls_q <= 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            ST_LS: begin
               if (req) begin
                  st   <= ST_WAKE;
                  ls_q <= 1'b0;
               end
            end
            ST_WAKE: st <= ST_RUN;
            default: begin
               st   <= ST_RUN;
               ls_q <= 1'b0;
            end
         endcase
      end
   end

   // Combinational req term gives the clock back in the same cycle it is asked for.
   assign en   = req | (st == ST_RUN) | (st == ST_HOLD) | (st == ST_WAKE);
   assign ls   = ls_q & ~test_mode;
   assign rdy  = en & (st != ST_LS) & (st != ST_WAKE);
   assign idle = (st == ST_OFF) | (st == ST_LS);

   e203_clkgate u_cg (
      .clk_in    (clk),
      .test_mode (test_mode),
      .clock_en  (en),
      .clk_out   (clk_out)
   );

endmodule

// File: rtl/e203_clkgate_mgr.sv
// Multi-channel clock gate manager: request decode, one gating channel per
// domain, registered all-idle flag and the always-on clock.
module e203_clkgate_mgr
   import e203_clkgate_mgr_pkg::*;
#(
   parameter int              N_CH     = 6,
   parameter logic [N_CH-1:0] WFI_MASK = 6'b000001,
   parameter logic [N_CH-1:0] LS_MASK  = 6'b110000,
   parameter int              HOLD_CYC = 1,
   parameter int              LS_DLY   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            test_mode,
   input  logic            core_cgstop,
   input  logic            core_wfi,
   input  logic [N_CH-1:0] chan_active,
   output logic [N_CH-1:0] clk_out,
   output logic [N_CH-1:0] chan_ls,
   output logic [N_CH-1:0] chan_rdy,
   output logic            clk_aon,
   output logic            all_idle
);

   localparam int CW = cw_of(HOLD_CYC, LS_DLY);

   logic [N_CH-1:0] req;
   logic [N_CH-1:0] idle;

   assign req = {N_CH{core_cgstop}} | (chan_active & ~({N_CH{core_wfi}} & WFI_MASK));

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      e203_clkgate_chan #(
         .HOLD_CYC (HOLD_CYC),
         .LS_DLY   (LS_DLY),
         .LS_EN    (LS_MASK[gi]),
         .CW       (CW)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .test_mode (test_mode),
         .req       (req[gi]),
         .clk_out   (clk_out[gi]),
         .ls        (chan_ls[gi]),
         .rdy       (chan_rdy[gi]),
         .idle      (idle[gi])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) all_idle <= 1'b0;
      else     all_idle <= &idle;
   end

   assign clk_aon = clk;

endmodule

// File: tb/tb_e203_clkgate_mgr.sv
// Bench for e203_clkgate_mgr: three parameterisations driven in parallel and
// compared each cycle against an idle-run-length model of channel behaviour.
module tb_e203_clkgate_mgr;

   localparam logic [5:0] WFI_M = 6'b000001;
   localparam logic [5:0] LS_M  = 6'b110000;
   localparam int         ND    = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       test_mode = 1'b0;
   logic       core_cgstop = 1'b0;
   logic       core_wfi = 1'b0;
   logic [5:0] chan_active = 6'h00;

   logic [5:0] clk_out_w  [ND];
   logic [5:0] chan_ls_w  [ND];
   logic [5:0] chan_rdy_w [ND];
   logic       clk_aon_w  [ND];
   logic       all_idle_w [ND];

   int checks = 0;
   int errors = 0;

   // Model: per channel, number of consecutive request-free edges since the
   // domain was last running, plus a flag for the single wake cycle.
   int h_m [ND] = '{1, 3, 0};
   int d_m [ND] = '{4, 4, 0};
   int n_m [ND][6];
   bit wk_m[ND][6];

   e203_clkgate_mgr #(.HOLD_CYC(1), .LS_DLY(4)) dut_a (
      .clk(clk), .rst(rst), .test_mode(test_mode), .core_cgstop(core_cgstop),
      .core_wfi(core_wfi), .chan_active(chan_active), .clk_out(clk_out_w[0]),
      .chan_ls(chan_ls_w[0]), .chan_rdy(chan_rdy_w[0]), .clk_aon(clk_aon_w[0]),
      .all_idle(all_idle_w[0]));

   e203_clkgate_mgr #(.HOLD_CYC(3), .LS_DLY(4)) dut_b (
      .clk(clk), .rst(rst), .test_mode(test_mode), .core_cgstop(core_cgstop),
      .core_wfi(core_wfi), .chan_active(chan_active), .clk_out(clk_out_w[1]),
      .chan_ls(chan_ls_w[1]), .chan_rdy(chan_rdy_w[1]), .clk_aon(clk_aon_w[1]),
      .all_idle(all_idle_w[1]));

   e203_clkgate_mgr #(.HOLD_CYC(0), .LS_DLY(0)) dut_c (
      .clk(clk), .rst(rst), .test_mode(test_mode), .core_cgstop(core_cgstop),
      .core_wfi(core_wfi), .chan_active(chan_active), .clk_out(clk_out_w[2]),
      .chan_ls(chan_ls_w[2]), .chan_rdy(chan_rdy_w[2]), .clk_aon(clk_aon_w[2]),
      .all_idle(all_idle_w[2]));

   always #5 clk = ~clk;

   function automatic logic [5:0] req_f();
      return {6{core_cgstop}} | (chan_active & ~({6{core_wfi}} & WFI_M));
   endfunction

   function automatic bit clocked_f(int d, int c);
      return wk_m[d][c] || (n_m[d][c] <= h_m[d]);
   endfunction

   function automatic bit asleep_f(int d, int c);
      return !wk_m[d][c] && LS_M[c] && (n_m[d][c] >= h_m[d] + 1 + d_m[d]);
   endfunction

   function automatic bit idle_f(int d, int c);
      return !wk_m[d][c] && (n_m[d][c] >= h_m[d] + 1);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 6; c++) begin
            n_m[d][c]  = 0;
            wk_m[d][c] = 1'b0;
         end
   endtask

   task automatic model_edge(input logic [5:0] r);
      for (int d = 0; d < ND; d++)
         for (int c = 0; c < 6; c++) begin
            if (wk_m[d][c]) begin
               wk_m[d][c] = 1'b0;
               n_m[d][c]  = 0;
            end else if (asleep_f(d, c)) begin
               if (r[c]) wk_m[d][c] = 1'b1;
            end else if (r[c]) begin
               n_m[d][c] = 0;
            end else if (n_m[d][c] < 1000) begin
               n_m[d][c] = n_m[d][c] + 1;
            end
         end
   endtask

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
      end
   endtask

   // Called in the low phase with inputs settled; checks just after the next rising edge.
   task automatic step();
      logic [5:0] r;
      logic [5:0] en_e [ND];
      logic       ai_e [ND];
      logic [5:0] ls_e;
      logic [5:0] rdy_e;
      logic [5:0] r2;
      r = req_f();
      for (int d = 0; d < ND; d++) begin
         ai_e[d] = 1'b1;
         for (int c = 0; c < 6; c++) begin
            en_e[d][c] = r[c] | clocked_f(d, c);
            ai_e[d]    = ai_e[d] & idle_f(d, c);
         end
      end
      @(posedge clk);
      model_edge(r);
      #1;
      r2 = req_f();
      for (int d = 0; d < ND; d++) begin
         for (int c = 0; c < 6; c++) begin
            ls_e[c]  = asleep_f(d, c) & ~test_mode;
            rdy_e[c] = (r2[c] | clocked_f(d, c)) & ~wk_m[d][c] & ~asleep_f(d, c);
         end
         chk($sformatf("clk_out d%0d", d), clk_out_w[d], en_e[d] | {6{test_mode}});
         chk($sformatf("chan_ls d%0d", d), chan_ls_w[d], ls_e);
         chk($sformatf("chan_rdy d%0d", d), chan_rdy_w[d], rdy_e);
         chk($sformatf("all_idle d%0d", d), {5'd0, all_idle_w[d]}, {5'd0, ai_e[d]});
         chk($sformatf("clk_aon d%0d", d), {5'd0, clk_aon_w[d]}, 6'd1);
      end
      @(negedge clk);
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // Asynchronous reset asserted mid low phase, released at the next low phase.
   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("rst chan_ls d%0d", d), chan_ls_w[d], 6'h00);
         chk($sformatf("rst chan_rdy d%0d", d), chan_rdy_w[d], 6'h3F);
         chk($sformatf("rst all_idle d%0d", d), {5'd0, all_idle_w[d]}, 6'd0);
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++)
         chk($sformatf("rst clk_out d%0d", d), clk_out_w[d], 6'h3F);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("reset clk_out d%0d", d), clk_out_w[d], 6'h3F);
         chk($sformatf("reset chan_ls d%0d", d), chan_ls_w[d], 6'h00);
         chk($sformatf("reset chan_rdy d%0d", d), chan_rdy_w[d], 6'h3F);
         chk($sformatf("reset all_idle d%0d", d), {5'd0, all_idle_w[d]}, 6'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      // Idle after reset: gate, then memories drop into light sleep.
      steps(12);
      chk("idle ls mask A", chan_ls_w[0], 6'h30);
      chk("idle all_idle A", {5'd0, all_idle_w[0]}, 6'd1);

      // WFI suppresses channel 0 only; releasing WFI restores it immediately.
      chan_active = 6'h3F;
      core_wfi    = 1'b1;
      steps(10);
      core_wfi = 1'b0;
      steps(3);

      // Light-sleep wake on a single-cycle request.
      chan_active = 6'h00;
      steps(12);
      chan_active = 6'h20;
      step();
      chan_active = 6'h00;
      steps(10);

      // Hysteresis retrigger on channel 2.
      chan_active = 6'h04;
      steps(3);
      chan_active = 6'h00;
      step();
      chan_active = 6'h04;
      steps(3);
      chan_active = 6'h00;
      steps(12);

      // Global override out of LS, then test mode on top.
      core_cgstop = 1'b1;
      steps(3);
      test_mode = 1'b1;
      steps(2);
      core_cgstop = 1'b0;
      steps(10);
      test_mode = 1'b0;
      steps(3);

      // Asynchronous reset while in light sleep.
      async_reset();
      steps(12);

      // Randomized traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         chan_active = 6'($urandom) & 6'($urandom) & 6'($urandom);
         core_wfi    = ($urandom_range(0, 3) == 0);
         core_cgstop = ($urandom_range(0, 15) == 0);
         test_mode   = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 5) == 0) begin
            chan_active = 6'h00;
            core_cgstop = 1'b0;
            steps($urandom_range(1, 10));
         end
         if ($urandom_range(0, 99) == 0) async_reset();
         else step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
